// File: rtl/clkspec_pkg.sv
// Shared types and constants for the 16x16 shift-add multiply-accumulate.
// kreg width tracks the default iteration count (ITER == WIDTH == 16).
package clkspec_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam int WIDTH_DEF = 16;
  localparam int ITER_DEF  = WIDTH_DEF;
  localparam int CW        = $clog2(ITER_DEF);

endpackage

// File: rtl/clkspec_mulacc16_16_if.sv
// Operand/result handshake bundle between the divider back end and the
// reconstruct stage: q/dv/rm in with valid/ready, dd/rm_err out with valid/ready.
interface clkspec_mulacc16_16_if #(
  parameter int WIDTH = 16
) ();

  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   dv;
  logic [WIDTH-1:0]   rm;
  logic               in_valid;
  logic               in_ready;
  logic [2*WIDTH-1:0] dd;
  logic               rm_err;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output q, dv, rm, in_valid, out_ready,
    input  in_ready, dd, rm_err, out_valid
  );

  modport slave (
    input  q, dv, rm, in_valid, out_ready,
    output in_ready, dd, rm_err, out_valid
  );

endinterface

// File: rtl/clkspec_mulacc_step.sv
// One combinational shift-add step: conditionally add the shifted multiplicand,
// then shift it left for the next multiplier bit.
module clkspec_mulacc_step #(
  parameter int W2 = 32
) (
  input  logic [W2-1:0] acc,
  input  logic [W2-1:0] areg,
  input  logic          mbit,
  output logic [W2-1:0] acc_nxt,
  output logic [W2-1:0] areg_nxt
);

  // No carry-out is possible: q*dv+rm tops out at 2^(2W)-2^W.
  assign acc_nxt  = mbit ? (acc + areg) : acc;
  assign areg_nxt = areg << 1;

endmodule

// File: rtl/clkspec_mulacc16_16.sv
// Sequential q*dv+rm over ITER shift-add cycles; one operation in flight,
// result held in DONE until out_ready, no input accepted outside IDLE.
module clkspec_mulacc16_16
  import clkspec_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ITER  = WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  clkspec_mulacc16_16_if.slave   bus
);

  localparam int W2 = 2 * WIDTH;

  state_t          state;
  state_t          state_nxt;
  logic [WIDTH-1:0] mreg;
  logic [W2-1:0]   areg;
  logic [W2-1:0]   acc;
  logic [W2-1:0]   acc_step;
  logic [W2-1:0]   areg_step;
  logic [CW-1:0]   kreg;
  logic            rm_err_r;
  logic [W2-1:0]   dd_r;
  logic            rm_err_q;

  clkspec_mulacc_step #(
    .W2 (W2)
  ) u_step (
    .acc      (acc),
    .areg     (areg),
    .mbit     (mreg[0]),
    .acc_nxt  (acc_step),
    .areg_nxt (areg_step)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = S_CALC;
      end
      S_CALC: begin
        if (kreg == '0) state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mreg     <= '0;
      areg     <= '0;
      acc      <= '0;
      kreg     <= '0;
      rm_err_r <= 1'b0;
      dd_r     <= '0;
      rm_err_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            mreg     <= bus.q;
            areg     <= {{WIDTH{1'b0}}, bus.dv};
            acc      <= {{WIDTH{1'b0}}, bus.rm};
            kreg     <= CW'(ITER - 1);
            rm_err_r <= (bus.dv != '0) && (bus.rm >= bus.dv);
          end
        end
        S_CALC: begin
          acc  <= acc_step;
          areg <= areg_step;
          mreg <= mreg >> 1;
          kreg <= kreg - CW'(1);
          // Capture on the final add so dd/rm_err stay frozen through DONE and after.
          if (kreg == '0) begin
            dd_r     <= acc_step;
            rm_err_q <= rm_err_r;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.dd     = dd_r;
  assign bus.rm_err = rm_err_q;

endmodule

// File: tb/tb_clkspec_mulacc16_16.sv
// Directed bench for clkspec_mulacc16_16: hand-computed vectors, latency,
// backpressure, mid-operation reset and back-to-back spacing.
module tb_clkspec_mulacc16_16;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  clkspec_mulacc16_16_if #(.WIDTH(16)) bus ();

  clkspec_mulacc16_16 #(.WIDTH(16), .ITER(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one op, check latency and result, then complete the handshake.
  task automatic run_op(input string tag, input logic [15:0] q, input logic [15:0] dv,
                        input logic [15:0] rm, input logic [31:0] exp_dd, input logic exp_err);
    int n;
    bus.q = q; bus.dv = dv; bus.rm = rm; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    chk({tag, "_rdy_before"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (bus.out_valid) break;
    end
    chk({tag, "_latency"}, 32'(n), 32'd16);
    chk({tag, "_dd"}, bus.dd, exp_dd);
    chk({tag, "_err"}, 32'(bus.rm_err), 32'(exp_err));
    chk({tag, "_no_bypass"}, 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_idle_after"}, {30'd0, bus.in_ready, bus.out_valid}, 32'h2);
  endtask

  logic [15:0] bq  [4];
  logic [15:0] bdv [4];
  logic [15:0] brm [4];
  logic [31:0] bdd [4];
  logic        berr[4];
  int          acc_t[4];

  initial begin
    int  i;
    int  r;
    int  cyc;
    logic will_accept;
    logic seen_valid;

    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.q = '0; bus.dv = '0; bus.rm = '0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_dd", bus.dd, 32'd0);
    chk("reset_rm_err", 32'(bus.rm_err), 32'd0);

    run_op("basic",   16'd14,   16'd7,    16'd2,    32'h0000_0064, 1'b0);
    run_op("max",     16'hFFFF, 16'hFFFF, 16'hFFFE, 32'hFFFE_FFFF, 1'b0);
    run_op("bad_rm",  16'd3,    16'd5,    16'd5,    32'd20,        1'b1);
    run_op("dv_zero", 16'h1234, 16'd0,    16'h0055, 32'h0000_0055, 1'b0);
    run_op("q_zero",  16'd0,    16'h1234, 16'h0010, 32'h0000_0010, 1'b0);

    // Backpressure: hold DONE for 5 cycles while a competing op is offered.
    bus.q = 16'h00AB; bus.dv = 16'h0100; bus.rm = 16'h00FF; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 40 && !bus.out_valid; k++) tick();
    bus.q = 16'h0001; bus.dv = 16'h0001; bus.rm = 16'h0000; bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold", {bus.in_ready, bus.out_valid, bus.rm_err}, {3'b010});
      chk("bp_dd", bus.dd, 32'h0000_ABFF);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bp_released", {30'd0, bus.in_ready, bus.out_valid}, 32'h2);
    chk("bp_dd_kept", bus.dd, 32'h0000_ABFF);
    tick();
    chk("bp_not_accepted", 32'(bus.in_ready), 32'd1);

    // Reset during the 8th CALC cycle.
    bus.q = 16'hFFFF; bus.dv = 16'hFFFF; bus.rm = 16'h0001; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_dd", bus.dd, 32'd0);
    seen_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.out_valid) seen_valid = 1'b1;
    end
    chk("midrst_no_pulse", 32'(seen_valid), 32'd0);
    run_op("after_rst", 16'd2, 16'd3, 16'd1, 32'd7, 1'b0);

    // Back-to-back: in_valid held, out_ready held.
    bq[0] = 16'd100;  bdv[0] = 16'd200; brm[0] = 16'd50; bdd[0] = 32'h0000_4E52; berr[0] = 1'b0;
    bq[1] = 16'hFFFF; bdv[1] = 16'd1;   brm[1] = 16'd0;  bdd[1] = 32'h0000_FFFF; berr[1] = 1'b0;
    bq[2] = 16'd7;    bdv[2] = 16'd9;   brm[2] = 16'd8;  bdd[2] = 32'd71;        berr[2] = 1'b0;
    bq[3] = 16'd1;    bdv[3] = 16'd3;   brm[3] = 16'd3;  bdd[3] = 32'd6;         berr[3] = 1'b1;
    i = 0; r = 0; cyc = 0;
    bus.out_ready = 1'b1;
    bus.q = bq[0]; bus.dv = bdv[0]; bus.rm = brm[0]; bus.in_valid = 1'b1;
    for (int c = 0; c < 200 && r < 4; c++) begin
      will_accept = bus.in_ready && (i < 4);
      tick();
      cyc++;
      if (will_accept) begin
        acc_t[i] = cyc;
        i++;
        if (i < 4) begin
          bus.q = bq[i]; bus.dv = bdv[i]; bus.rm = brm[i];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (bus.out_valid && r < 4) begin
        chk("b2b_dd", bus.dd, bdd[r]);
        chk("b2b_err", 32'(bus.rm_err), 32'(berr[r]));
        r++;
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk("b2b_results", 32'(r), 32'd4);
    for (int k = 1; k < 4; k++) chk("b2b_spacing", 32'(acc_t[k] - acc_t[k-1]), 32'd18);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
